hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage (IF, ID, EX, MEM, WB) RISC-V pipeline. It replaces the combinational load-use hazard and forwarding logic with a per-register pending-write scoreboard. It adds a memory-ready handshake that freezes the pipeline, and a saturating stall-cycle counter. It sits beside the pipeline registers and drives their enable and flush controls plus the EX-stage operand forwarding muxes.

---
 rtl/hazard_scoreboard_if.sv | 27 ++
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit bundle: stage register/enable info in, stall/flush/forward controls out.
interface hazard_scoreboard_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  Rs1D, Rs2D, RdD;
    logic             UsesRs1D, UsesRs2D, RegWriteD, IsLoadD, ValidD;
    logic [RA_W-1:0]  Rs1E, Rs2E, RdM, RdW;
    logic             RegWriteM, RegWriteW, PCSrcE, MemReadyM;
    logic             StallF, StallD, StallE, StallM, BubbleW, FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output Rs1D, Rs2D, RdD, UsesRs1D, UsesRs2D, RegWriteD, IsLoadD, ValidD,
               Rs1E, Rs2E, RdM, RdW, RegWriteM, RegWriteW, PCSrcE, MemReadyM,
        input  StallF, StallD, StallE, StallM, BubbleW, FlushD, FlushE,
               ForwardAE, ForwardBE, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, UsesRs1D, UsesRs2D, RegWriteD, IsLoadD, ValidD,
               Rs1E, Rs2E, RdM, RdW, RegWriteM, RegWriteW, PCSrcE, MemReadyM,
        output StallF, StallD, StallE, StallM, BubbleW, FlushD, FlushE,
               ForwardAE, ForwardBE, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard/forwarding control for the 5-stage pipeline; HAZARD_FWD_EN enables EX forwarding.
// Latency: controls are combinational (zero cycles); scoreboard and stall counter update on clk.
// Backpressure: MemReadyM low freezes everything; RAW stalls IF/ID and bubbles EX; taken branch flushes.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int RA_W  = $clog2(NREG),
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic reset,
    hazard_scoreboard_if.slave hz
);

    logic [1:0]       cnt [NREG];
    logic [CNT_W-1:0] stallCount;
    logic [1:0]       cntRs1, cntRs2, latency;
    logic             freeze, raw, issue, countEvt;

    // x0 is never tracked, so it can never look busy.
    assign cntRs1   = (hz.Rs1D != '0) ? cnt[hz.Rs1D] : 2'd0;
    assign cntRs2   = (hz.Rs2D != '0) ? cnt[hz.Rs2D] : 2'd0;
    assign freeze   = ~hz.MemReadyM;
    assign raw      = (hz.UsesRs1D & (cntRs1 > 2'd1)) | (hz.UsesRs2D & (cntRs2 > 2'd1));
    assign issue    = hz.ValidD & hz.RegWriteD & (hz.RdD != '0) & ~freeze & ~hz.PCSrcE & ~raw;
    assign countEvt = freeze | (raw & ~hz.PCSrcE);

`ifdef HAZARD_FWD_EN
    assign latency = hz.IsLoadD ? 2'd2 : 2'd1;
`else
    // Without forwarding a consumer must wait until its producer reaches WB.
    assign latency = 2'd3;
    logic unusedNoFwd;
    assign unusedNoFwd = ^{hz.IsLoadD, hz.Rs1E, hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW};
`endif

    always_comb begin
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.BubbleW   = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (reset) begin
            if (freeze) begin
                hz.StallF  = 1'b1;
                hz.StallD  = 1'b1;
                hz.StallE  = 1'b1;
                hz.StallM  = 1'b1;
                hz.BubbleW = 1'b1;
            end else if (hz.PCSrcE) begin
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
            end else if (raw) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
`ifdef HAZARD_FWD_EN
            // MEM holds the younger result, so it takes priority over WB.
            if (hz.RegWriteM && hz.RdM != '0 && hz.RdM == hz.Rs1E)
                hz.ForwardAE = 2'b10;
            else if (hz.RegWriteW && hz.RdW != '0 && hz.RdW == hz.Rs1E)
                hz.ForwardAE = 2'b01;
            if (hz.RegWriteM && hz.RdM != '0 && hz.RdM == hz.Rs2E)
                hz.ForwardBE = 2'b10;
            else if (hz.RegWriteW && hz.RdW != '0 && hz.RdW == hz.Rs2E)
                hz.ForwardBE = 2'b01;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
            stallCount <= '0;
        end else begin
            if (!freeze) begin
                for (int r = 1; r < NREG; r++) begin
                    if (issue && hz.RdD == RA_W'(r))
                        cnt[r] <= latency;
                    else if (cnt[r] != 2'd0)
                        cnt[r] <= cnt[r] - 2'd1;
                end
            end
            if (countEvt && stallCount != '1)
                stallCount <= stallCount + 1'b1;
        end
    end

    assign hz.StallCount = stallCount;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow the HAZARD_FWD_EN setting of the build.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
    localparam int LOADLAT = 2;
    localparam int ALULAT  = 1;
    localparam int FWD     = 1;
`else
    localparam int LOADLAT = 3;
    localparam int ALULAT  = 3;
    localparam int FWD     = 0;
`endif

    // {StallF, StallD, StallE, StallM, BubbleW, FlushD, FlushE}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RAW  = 7'b1100001;
    localparam logic [6:0] C_BR   = 7'b0000011;
    localparam logic [6:0] C_FRZ  = 7'b1111100;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   expCnt   = 0;

    hazard_scoreboard_if #(.RA_W(5), .CNT_W(32)) hif ();

    hazard_scoreboard #(.NREG(32), .RA_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ctlNow();
        return {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.BubbleW, hif.FlushD, hif.FlushE};
    endfunction

    task automatic chkCtl(input string tag, input logic [6:0] e);
        chk({tag, "/ctl"}, 32'(ctlNow()), 32'(e));
    endtask

    task automatic chkFwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, "/fwdA"}, 32'(hif.ForwardAE), 32'(a));
        chk({tag, "/fwdB"}, 32'(hif.ForwardBE), 32'(b));
    endtask

    task automatic chkCount(input string tag);
        chk({tag, "/stallCount"}, hif.StallCount, 32'(expCnt));
    endtask

    task automatic idle();
        hif.ValidD = 1'b0; hif.RegWriteD = 1'b0; hif.IsLoadD = 1'b0;
        hif.UsesRs1D = 1'b0; hif.UsesRs2D = 1'b0;
        hif.Rs1D = '0; hif.Rs2D = '0; hif.RdD = '0;
        hif.Rs1E = '0; hif.Rs2E = '0; hif.RdM = '0; hif.RdW = '0;
        hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.PCSrcE = 1'b0; hif.MemReadyM = 1'b1;
    endtask

    task automatic idD(input logic wr, input logic ld, input logic [4:0] rd,
                       input logic u1, input logic [4:0] rs1, input logic u2, input logic [4:0] rs2);
        hif.ValidD = 1'b1; hif.RegWriteD = wr; hif.IsLoadD = ld; hif.RdD = rd;
        hif.UsesRs1D = u1; hif.Rs1D = rs1; hif.UsesRs2D = u2; hif.Rs2D = rs2;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        idle();
        repeat (4) step();
    endtask

    initial begin
        // Reset asserted with hostile inputs: every control must read zero.
        reset = 1'b1;
        idle();
        #1 reset = 1'b0;
        hif.MemReadyM = 1'b0; hif.PCSrcE = 1'b1; hif.RegWriteM = 1'b1; hif.RdM = 5'd3;
        hif.Rs1E = 5'd3; hif.ValidD = 1'b1; hif.UsesRs1D = 1'b1; hif.Rs1D = 5'd5;
        #2;
        chkCtl("reset", C_NONE);
        chkFwd("reset", 2'd0, 2'd0);
        chk("reset/stallCount", hif.StallCount, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle();
        step();

        // Load-use: lw x5 ; add x6, x5, x1
        idD(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chkCtl("lu.lw", C_NONE);
        step();
        idD(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1);
        for (int i = 0; i < LOADLAT - 1; i++) begin
            #1 chkCtl("lu.stall", C_RAW);
            expCnt++;
            step();
        end
        #1 chkCtl("lu.go", C_NONE);
        step();
        idle();
        hif.Rs1E = 5'd5; hif.Rs2E = 5'd1; hif.RegWriteW = 1'b1; hif.RdW = 5'd5;
        #1 chkFwd("lu.ex", (FWD != 0) ? 2'd1 : 2'd0, 2'd0);
        chkCount("lu");
        step();
        drain();

        // ALU chain: add x5 ; sub x7, x5, x5
        idD(1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chkCtl("alu.add", C_NONE);
        step();
        idD(1'b1, 1'b0, 5'd7, 1'b1, 5'd5, 1'b1, 5'd5);
        for (int i = 0; i < ALULAT - 1; i++) begin
            #1 chkCtl("alu.stall", C_RAW);
            expCnt++;
            step();
        end
        #1 chkCtl("alu.go", C_NONE);
        step();
        idle();
        hif.Rs1E = 5'd5; hif.Rs2E = 5'd5;
        hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.RegWriteW = 1'b1; hif.RdW = 5'd5;
        #1 chkFwd("alu.ex", (FWD != 0) ? 2'd2 : 2'd0, (FWD != 0) ? 2'd2 : 2'd0);
        hif.Rs2E = 5'd9; hif.RdW = 5'd9;
        #1 chkFwd("alu.wb", (FWD != 0) ? 2'd2 : 2'd0, (FWD != 0) ? 2'd1 : 2'd0);
        chkCount("alu");
        step();
        drain();

        // x0 destination: lw x0 ; add x6, x0, x0
        idD(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chkCtl("x0.lw", C_NONE);
        step();
        idD(1'b1, 1'b0, 5'd6, 1'b1, 5'd0, 1'b1, 5'd0);
        #1 chkCtl("x0.dep", C_NONE);
        step();
        idle();
        hif.RegWriteM = 1'b1; hif.RdM = 5'd0; hif.RegWriteW = 1'b1; hif.RdW = 5'd0;
        #1 chkFwd("x0.ex", 2'd0, 2'd0);
        step();
        drain();

        // Taken branch in the same cycle as a RAW hazard; the ID write to x8 must not issue.
        idD(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        idD(1'b1, 1'b0, 5'd8, 1'b1, 5'd5, 1'b0, 5'd0);
        hif.PCSrcE = 1'b1;
        #1 chkCtl("br.flush", C_BR);
        step();
        idle();
        idD(1'b1, 1'b0, 5'd9, 1'b1, 5'd8, 1'b0, 5'd0);
        #1 chkCtl("br.x8free", C_NONE);
        chkCount("br");
        step();
        drain();

        // Memory wait for 3 cycles with cnt[x5] = 2; freeze outranks a branch.
        idD(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        idle();
        for (int i = 0; i < LOADLAT - 2; i++) step();
        idD(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
        hif.MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hif.PCSrcE = (i == 1);
            #1 chkCtl("mem.freeze", C_FRZ);
            expCnt++;
            step();
        end
        hif.MemReadyM = 1'b1;
        hif.PCSrcE = 1'b0;
        #1 chkCtl("mem.held2", C_RAW);
        expCnt++;
        step();
        #1 chkCtl("mem.go", C_NONE);
        chkCount("mem");
        step();
        drain();

        // Asynchronous reset between edges while x5 is pending and a stall is active.
        idD(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        idle();
        for (int i = 0; i < LOADLAT - 2; i++) step();
        idD(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
        hif.Rs1E = 5'd5; hif.RegWriteM = 1'b1; hif.RdM = 5'd5;
        #1 chkCtl("arst.pre", C_RAW);
        chkCount("arst.pre");
        #2 reset = 1'b0;
        #1 chkCtl("arst.during", C_NONE);
        chkFwd("arst.during", 2'd0, 2'd0);
        chk("arst.during/stallCount", hif.StallCount, 32'd0);
        expCnt = 0;
        step();
        #1 reset = 1'b1;
        idle();
        idD(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1);
        #1 chkCtl("arst.post", C_NONE);
        step();
        chkCount("arst.post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
